// File: rtl/draw_rect_char_pkg.sv
// Shared constants and types for the text-box overlay: VGA widths,
// character cell geometry and the pixel pipeline depth.
package draw_rect_char_pkg;

   localparam int CNT_W      = 11;
   localparam int RGB_W      = 12;
   localparam int CHAR_W     = 8;
   localparam int CHAR_H     = 16;
   localparam int GRID       = 16;
   localparam int PIPE_DEPTH = 3;
   localparam int BOX_W      = CHAR_W * GRID;
   localparam int BOX_H      = CHAR_H * GRID;
   localparam int CNT_MAX    = 2047;

   // One pixel's worth of VGA bus, packed so it can ride through a delay line.
   typedef struct packed {
      logic [CNT_W-1:0] hcount;
      logic [CNT_W-1:0] vcount;
      logic             hsync;
      logic             vsync;
      logic             hblnk;
      logic             vblnk;
      logic [RGB_W-1:0] rgb;
   } vga_t;

   function automatic logic in_span(input logic [CNT_W-1:0] val, input int lo, input int len);
      return (int'(val) >= lo) && (int'(val) < lo + len);
   endfunction

endpackage

// File: rtl/draw_rect_char_if.sv
// VGA pixel bus: counters, sync/blank timing and colour for one pixel.
interface draw_rect_char_if;

   logic [draw_rect_char_pkg::CNT_W-1:0] hcount;
   logic [draw_rect_char_pkg::CNT_W-1:0] vcount;
   logic                                 hsync;
   logic                                 vsync;
   logic                                 hblnk;
   logic                                 vblnk;
   logic [draw_rect_char_pkg::RGB_W-1:0] rgb;

   modport master (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport slave  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);

endinterface

// File: rtl/draw_rect_char_signal_delay.sv
// Fixed-depth shift register delay line with asynchronous clear.
module signal_delay #(
   parameter int WIDTH = 1,
   parameter int DEPTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] i_data,
   output logic [WIDTH-1:0] o_data
);

   logic [WIDTH-1:0] r_pipe [DEPTH];

   // NOTE: every stage is cleared on reset because these are output-visible
   // pipeline flops, not a storage memory; a RAM-style array would not be reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) r_pipe[i] <= '0;
      end else begin
         r_pipe[0] <= i_data;
         for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
      end
   end

   assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/draw_rect_char.sv
// Overlays a 16x16 grid of 8x16 glyphs onto a VGA stream; addresses the
// external code/font ROMs and delays the pixel bus to match their latency.
module draw_rect_char
   import draw_rect_char_pkg::*;
#(
   parameter int               XPOS         = 300,
   parameter int               YPOS         = 200,
   parameter logic [RGB_W-1:0] LETTER_COLOR = 12'hFFF
) (
   input  logic                    clk,
   input  logic                    rst_n,
   draw_rect_char_if.slave         vga_in,
   draw_rect_char_if.master        vga_out,
   input  logic                    text_en,
   input  logic [7:0]              char_pixels,
   output logic [7:0]              char_xy,
   output logic [3:0]              char_line
);

   if ((XPOS + BOX_W > CNT_MAX) || (YPOS + BOX_H > CNT_MAX) || (XPOS < 0) || (YPOS < 0)) begin : g_bad_cfg
      $error("draw_rect_char: text box does not fit in the 11-bit pixel space");
   end

   logic       w_in_box;
   logic [6:0] w_rel_x;
   logic [7:0] w_rel_y;
   logic       w_vsync_rise;
   vga_t       w_bus_in;
   vga_t       w_bus_dly;

   logic       r_vsync_prev;
   logic       r_frame_en;
   logic [7:0] r_char_xy;
   logic [3:0] r_char_line;
   logic       r_in_box1, r_in_box2;
   logic [2:0] r_bit_idx1, r_bit_idx2;
   logic       r_blank1, r_blank2;
   logic       r_lit;

   // Relative offsets are only consumed under w_in_box, so truncation cannot alias.
   assign w_in_box     = in_span(vga_in.hcount, XPOS, BOX_W) && in_span(vga_in.vcount, YPOS, BOX_H);
   assign w_rel_x      = 7'(vga_in.hcount - 11'(XPOS));
   assign w_rel_y      = 8'(vga_in.vcount - 11'(YPOS));
   assign w_vsync_rise = vga_in.vsync && !r_vsync_prev;

   // NOTE: state registers use non-blocking assignments so every stage samples
   // the previous cycle's value regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vsync_prev <= 1'b0;
         r_frame_en   <= 1'b0;
         r_char_xy    <= '0;
         r_char_line  <= '0;
         r_in_box1    <= 1'b0;
         r_in_box2    <= 1'b0;
         r_bit_idx1   <= '0;
         r_bit_idx2   <= '0;
         r_blank1     <= 1'b0;
         r_blank2     <= 1'b0;
         r_lit        <= 1'b0;
      end else begin
         r_vsync_prev <= vga_in.vsync;
         if (w_vsync_rise) r_frame_en <= text_en;

         // Stage 1: ROM addressing
         r_in_box1   <= w_in_box;
         r_char_xy   <= w_in_box ? {w_rel_y[7:4], w_rel_x[6:3]} : 8'h00;
         r_char_line <= w_in_box ? w_rel_y[3:0] : 4'h0;
         r_bit_idx1  <= 3'd7 - w_rel_x[2:0];
         r_blank1    <= vga_in.hblnk || vga_in.vblnk;

         // Stage 2: wait for the font ROM
         r_in_box2  <= r_in_box1;
         r_bit_idx2 <= r_bit_idx1;
         r_blank2   <= r_blank1;

         // Stage 3: glyph pixel decision, aligned with the 3-deep bus delay
         r_lit <= r_in_box2 && r_frame_en && char_pixels[r_bit_idx2] && !r_blank2;
      end
   end

   assign w_bus_in = '{hcount: vga_in.hcount, vcount: vga_in.vcount,
                       hsync:  vga_in.hsync,  vsync:  vga_in.vsync,
                       hblnk:  vga_in.hblnk,  vblnk:  vga_in.vblnk,
                       rgb:    vga_in.rgb};

   signal_delay #(
      .WIDTH ($bits(vga_t)),
      .DEPTH (PIPE_DEPTH)
   ) u_bus_delay (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_data (w_bus_in),
      .o_data (w_bus_dly)
   );

   assign char_xy        = r_char_xy;
   assign char_line      = r_char_line;
   assign vga_out.hcount = w_bus_dly.hcount;
   assign vga_out.vcount = w_bus_dly.vcount;
   assign vga_out.hsync  = w_bus_dly.hsync;
   assign vga_out.vsync  = w_bus_dly.vsync;
   assign vga_out.hblnk  = w_bus_dly.hblnk;
   assign vga_out.vblnk  = w_bus_dly.vblnk;
   // Both mux inputs are stage-3 flops, so the output stays a registered value.
   assign vga_out.rgb    = r_lit ? LETTER_COLOR : w_bus_dly.rgb;

endmodule

// File: tb/tb_draw_rect_char.sv
// Directed bench for draw_rect_char: streamed vector table plus reset,
// frame-enable and mid-frame reset sequences against a registered font stub.
module tb_draw_rect_char;

   logic       clk;
   logic       rst_n;
   logic       text_en;
   logic [7:0] char_pixels;
   logic [7:0] char_xy;
   logic [3:0] char_line;

   int n_checks = 0;
   int n_errors = 0;

   draw_rect_char_if vin ();
   draw_rect_char_if vout ();

   draw_rect_char dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .vga_in      (vin),
      .vga_out     (vout),
      .text_en     (text_en),
      .char_pixels (char_pixels),
      .char_xy     (char_xy),
      .char_line   (char_line)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Font ROM stub with one-clock latency: line 5 holds 8'h01, every other line 8'h80.
   always @(posedge clk) char_pixels <= (char_line == 4'd5) ? 8'h01 : 8'h80;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   typedef struct {
      logic [10:0] h;
      logic [10:0] v;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [7:0]  xy;
      logic [3:0]  line;
      logic [11:0] exp_rgb;
   } vec_t;

   localparam int N = 15;
   vec_t vecs [N];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic set_pix(input logic [10:0] h, input logic [10:0] v, input logic [11:0] rgb);
      vin.hcount = h;
      vin.vcount = v;
      vin.rgb    = rgb;
      vin.hblnk  = 1'b0;
      vin.vblnk  = 1'b0;
      vin.hsync  = 1'b0;
   endtask

   task automatic hold(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic vs_pulse();
      vin.vsync = 1'b1;
      hold(1);
      vin.vsync = 1'b0;
   endtask

   function automatic logic [25:0] timing_out();
      return {vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk};
   endfunction

   function automatic vec_t mk(input int h, input int v, input logic hb, input logic vb,
                               input logic [11:0] rgb, input logic [7:0] xy,
                               input logic [3:0] line, input logic [11:0] exp_rgb);
      vec_t r;
      r.h = 11'(h); r.v = 11'(v); r.hb = hb; r.vb = vb;
      r.rgb = rgb; r.xy = xy; r.line = line; r.exp_rgb = exp_rgb;
      return r;
   endfunction

   initial begin
      //            h     v    hb    vb    rgb_in   xy     line  rgb_out
      vecs[0]  = mk(300,  200, 1'b0, 1'b0, 12'h123, 8'h00, 4'd0,  12'hFFF);
      vecs[1]  = mk(301,  200, 1'b0, 1'b0, 12'h0A5, 8'h00, 4'd0,  12'h0A5);
      vecs[2]  = mk(308,  296, 1'b0, 1'b0, 12'h321, 8'h61, 4'd0,  12'hFFF);
      vecs[3]  = mk(427,  455, 1'b0, 1'b0, 12'h456, 8'hFF, 4'd15, 12'h456);
      vecs[4]  = mk(299,  200, 1'b0, 1'b0, 12'h789, 8'h00, 4'd0,  12'h789);
      vecs[5]  = mk(428,  200, 1'b0, 1'b0, 12'h9AB, 8'h00, 4'd0,  12'h9AB);
      vecs[6]  = mk(300,  199, 1'b0, 1'b0, 12'hBCD, 8'h00, 4'd0,  12'hBCD);
      vecs[7]  = mk(300,  456, 1'b0, 1'b0, 12'hCDE, 8'h00, 4'd0,  12'hCDE);
      vecs[8]  = mk(300,  200, 1'b1, 1'b0, 12'h111, 8'h00, 4'd0,  12'h111);
      vecs[9]  = mk(300,  200, 1'b0, 1'b1, 12'h222, 8'h00, 4'd0,  12'h222);
      vecs[10] = mk(307,  205, 1'b0, 1'b0, 12'h333, 8'h00, 4'd5,  12'hFFF);
      vecs[11] = mk(300,  205, 1'b0, 1'b0, 12'h444, 8'h00, 4'd5,  12'h444);
      vecs[12] = mk(315,  216, 1'b0, 1'b0, 12'h555, 8'h11, 4'd0,  12'h555);
      vecs[13] = mk(2047, 2047, 1'b0, 1'b0, 12'h666, 8'h00, 4'd0, 12'h666);
      vecs[14] = mk(0,    0,   1'b0, 1'b0, 12'h777, 8'h00, 4'd0,  12'h777);

      rst_n   = 1'b1;
      text_en = 1'b0;
      vin.vsync = 1'b0;
      set_pix(11'd0, 11'd0, 12'h000);

      // Asynchronous reset: outputs clear before any clock edge.
      #2 rst_n = 1'b0;
      #1;
      check("reset_rgb",    32'(vout.rgb), 32'h0);
      check("reset_timing", 32'(timing_out()), 32'h0);
      check("reset_xy",     32'(char_xy), 32'h0);
      check("reset_line",   32'(char_line), 32'h0);

      hold(2);
      set_pix(11'd308, 11'd296, 12'h0A5);
      rst_n = 1'b1;

      // First valid output lands on the third edge; no overlay before a vsync edge.
      hold(1);
      check("lat_xy_e1",  32'(char_xy), 32'h61);
      check("lat_h_e1",   32'(vout.hcount), 32'd0);
      hold(1);
      check("lat_h_e2",   32'(vout.hcount), 32'd0);
      hold(1);
      check("lat_h_e3",   32'(vout.hcount), 32'd308);
      check("no_ovl_pre", 32'(vout.rgb), 32'h0A5);

      text_en = 1'b1;
      hold(2);
      check("no_ovl_en",  32'(vout.rgb), 32'h0A5);
      vs_pulse();
      hold(3);
      check("ovl_on",     32'(vout.rgb), 32'hFFF);

      // Streamed table: one new pixel every clock, outputs checked at exact latency.
      for (int k = 0; k < N + 3; k++) begin
         if (k >= 1 && k <= N) begin
            check($sformatf("xy_%0d", k - 1),   32'(char_xy),   32'(vecs[k-1].xy));
            check($sformatf("line_%0d", k - 1), 32'(char_line), 32'(vecs[k-1].line));
         end
         if (k >= 3) begin
            check($sformatf("rgb_%0d", k - 3), 32'(vout.rgb), 32'(vecs[k-3].exp_rgb));
            check($sformatf("tim_%0d", k - 3), 32'(timing_out()),
                  32'({vecs[k-3].h, vecs[k-3].v, 1'((k - 3) % 2), 1'b0, vecs[k-3].hb, vecs[k-3].vb}));
         end
         if (k < N) begin
            vin.hcount = vecs[k].h;
            vin.vcount = vecs[k].v;
            vin.hblnk  = vecs[k].hb;
            vin.vblnk  = vecs[k].vb;
            vin.rgb    = vecs[k].rgb;
            vin.hsync  = 1'(k % 2);
         end else begin
            set_pix(11'd0, 11'd0, 12'h000);
         end
         hold(1);
      end

      // text_en dropped mid-frame: overlay holds until the next vsync edge.
      set_pix(11'd300, 11'd250, 12'h0A5);
      text_en = 1'b0;
      hold(3);
      check("drop_xy",      32'(char_xy), 32'h30);
      check("drop_line",    32'(char_line), 32'd2);
      check("drop_persist", 32'(vout.rgb), 32'hFFF);
      hold(4);
      check("drop_persist2", 32'(vout.rgb), 32'hFFF);
      vs_pulse();
      hold(3);
      check("drop_off",     32'(vout.rgb), 32'h0A5);
      set_pix(11'd300, 11'd200, 12'h5A5);
      hold(3);
      check("drop_off2",    32'(vout.rgb), 32'h5A5);

      // text_en rising together with vsync: the new value is taken.
      set_pix(11'd300, 11'd250, 12'h0A5);
      text_en = 1'b1;
      vs_pulse();
      hold(3);
      check("simul_en",     32'(vout.rgb), 32'hFFF);

      // Mid-frame reset: outputs clear at once, pipeline contents are dropped.
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_rgb",    32'(vout.rgb), 32'h0);
      check("mid_rst_timing", 32'(timing_out()), 32'h0);
      check("mid_rst_xy",     32'(char_xy), 32'h0);
      hold(1);
      rst_n = 1'b1;
      hold(2);
      check("post_rst_h_e2",  32'(vout.hcount), 32'd0);
      hold(1);
      check("post_rst_h_e3",  32'(vout.hcount), 32'd300);
      check("post_rst_noovl", 32'(vout.rgb), 32'h0A5);
      vs_pulse();
      hold(3);
      check("post_rst_ovl",   32'(vout.rgb), 32'hFFF);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/draw_rect_char.md
DRAW_RECT_CHAR -- requirements
Module: draw_rect_char

Interface
REQ-001 The module SHALL have parameter XPOS, default 300, giving the text box left edge in pixels.
REQ-002 The module SHALL have parameter YPOS, default 200, giving the text box top edge in pixels.
REQ-003 The module SHALL have parameter LETTER_COLOR, default 12'hFFF, giving the glyph foreground RGB444.
REQ-004 clk  input  1  pixel clock, single clock domain; rst_n  input  1  reset, asynchronous, active-low.
REQ-005 hcount_in, vcount_in  input  11 each  pixel position; hsync_in, vsync_in, hblnk_in, vblnk_in  input  1 each  timing.
REQ-006 rgb_in  input  12  upstream pixel colour; text_en  input  1  overlay request.
REQ-007 char_pixels  input  8  font row from the external synchronous font ROM, MSB = leftmost pixel.
REQ-008 char_xy  output  8  {row[3:0], col[3:0]} address to the character-code ROM.
REQ-009 char_line  output  4  glyph row 0..15, concatenated externally with the returned 7-bit code as the font ROM address.
REQ-010 hcount_out, vcount_out  output  11 each; hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each; rgb_out  output  12.

Function
REQ-011 The text box SHALL be 16 columns x 16 rows of 8x16-pixel cells, i.e. 128 x 256 pixels.
REQ-012 in_box SHALL be true iff XPOS <= hcount_in < XPOS+128 and YPOS <= vcount_in < YPOS+256.
REQ-013 rel_x = hcount_in-XPOS (7 bits) and rel_y = vcount_in-YPOS (8 bits) SHALL be computed without wrap-around; out-of-box pixels never alias into the box.
REQ-014 Stage 1, registered: char_xy = {rel_y[7:4], rel_x[6:3]}, char_line = rel_y[3:0], bit index = 7-rel_x[2:0]; char_xy and char_line SHALL be 0 when not in_box.
REQ-015 The code ROM is combinational and the font ROM has one-clock latency, so char_pixels SHALL be valid one clock after char_xy/char_line.
REQ-016 Stage 3, registered: rgb_out = LETTER_COLOR when the delayed in_box, frame_en and char_pixels[delayed bit index] are all 1 and both delayed blanks are 0; otherwise rgb_out SHALL equal the delayed rgb_in.
REQ-017 All timing, count and rgb outputs SHALL equal their inputs delayed by exactly 3 clocks.
REQ-018 frame_en SHALL load text_en only on a vsync_in rising edge (vsync_in=1 with the previous registered value 0), so a text_en change mid-frame takes effect from the next frame.
REQ-019 Simultaneous text_en change and vsync rising edge: the new text_en value SHALL be taken.
REQ-020 Parameter legality: XPOS+128 <= 2047 and YPOS+256 <= 2047; violations are a configuration error.

Reset
REQ-021 While rst_n=0 all outputs, pipeline registers, the vsync edge register and frame_en SHALL be 0, immediately and independent of clk.
REQ-022 After release, the first output SHALL carry valid data on the 3rd rising edge; no overlay SHALL appear until the first vsync rising edge with text_en=1.
REQ-023 Reset asserted mid-frame SHALL abandon the in-flight pipeline contents, with no recovery of partial data.

Structure
REQ-024 The shared package SHALL hold the VGA widths (count 11, rgb 12), CHAR_W=8, CHAR_H=16, GRID=16 and the pipeline depth constant 3.
REQ-025 The timing/rgb/count path SHALL use one sub-module, signal_delay (parameters WIDTH and DEPTH, async active-low reset), instantiated with DEPTH=3.
REQ-026 The char_rom and font ROM SHALL stay outside this module and be connected at the parent level.

Verification
REQ-027 Scenario: reset, vsync edge with text_en=1, font-ROM stub returning 8'h80; hcount=300, vcount=200 -> char_xy=8'h00 and char_line=0 after 1 clk; rgb_out=12'hFFF after 3 clk.
REQ-028 Scenario: same stub, hcount=301, rgb_in=12'h0A5 -> rgb_out=12'h0A5 after 3 clk (bit 6 not lit).
REQ-029 Scenario: hcount=308, vcount=296 -> char_xy=8'h61, char_line=0; hcount=427, vcount=455 -> char_xy=8'hFF, char_line=15.
REQ-030 Scenario: hcount=299 or 428, or vcount=199 or 456 -> char_xy=0, char_line=0, rgb_out equals rgb_in delayed 3 clk.
REQ-031 Scenario: text_en dropped at vcount=250 -> overlay persists until the next vsync rising edge, then rgb_out passes through for the whole next frame; hblnk_in=1 inside the box -> no overlay.
REQ-032 Scenario: rst_n pulsed low mid-frame -> all outputs 0 within the same cycle; after release there is no overlay until a vsync edge with text_en=1.
